assoc_branch_target_buffer: RTL and testbench
=============================================

# assoc_branch_target_buffer

Set-associative branch target buffer for the pipelined fetch stage: given the fetch PC, predicts whether it holds a branch and supplies the target in the same cycle. It is trained by resolved-branch feedback from execute. It generalises the direct-mapped BTB with configurable associativity, round-robin replacement and an optional 2-bit direction counter. It also replaces the single-cycle reset clear with a sequenced invalidation sweep that can be re-triggered by a flush.

## Interface
- PC_W, default 16: PC width in bits.
- SETS_LOG2, default 4: log2 of set count; index = pc[SETS_LOG2-1:0], tag = pc[PC_W-1:SETS_LOG2].
- WAYS, default 2: ways per set; legal values 2, 4, 8.
- clk  in  1  clock; all state updates on posedge.
- n_rst  in  1  reset, synchronous, active-low.
- flush  in  1  single-cycle request to invalidate the whole BTB.
- pc  in  PC_W  fetch PC to look up.
- hit  out  1  valid entry with matching tag found in indexed set.
- branch  out  1  predict taken; 0 whenever hit=0.
- target  out  PC_W  predicted target; 0 whenever hit=0.
- ready  out  1  BTB initialised; 0 during sweep.
- fb_valid  in  1  feedback strobe for one resolved branch.
- fb_pc  in  PC_W  PC of resolved instruction.
- fb_taken  in  1  resolved direction.
- fb_target  in  PC_W  resolved target.

## Operation
- Entry fields: valid, tag, target, and either a 2-bit counter (BTB_COUNTER_EN) or a 1-bit taken flag. One round-robin pointer (log2 WAYS bits) per set.
- FSM states: INIT, READY.
- INIT: each cycle clears valid of all ways and the rr pointer of set init_idx, then init_idx++. After set 2^SETS_LOG2-1, go to READY. In INIT, ready=0, hit=0, and fb_valid is ignored.
- n_rst low: state=INIT, init_idx=0. Reset outputs: hit=0, branch=0, target=0, ready=0.
- flush in READY → INIT with init_idx=0. flush in INIT restarts the sweep at 0.
- Lookup is combinational on pc against all ways of the indexed set. Tags never duplicate within a set, so at most one way matches.
- Feedback hit (fb_pc tag matches a valid way): update that way in place. Target is overwritten only if fb_taken. The direction field updates per Configuration. No replacement occurs; rr is unchanged.
- Feedback miss (allocating case per Configuration): victim is the lowest-index invalid way, else rr[set]. rr[set] advances (mod WAYS) only when a valid way is evicted. Write valid=1, tag, target=fb_target, direction initial value.

## Timing
- Lookup latency: 0 cycles (combinational from pc).
- Feedback is visible to lookup on the cycle after fb_valid.
- Same-cycle feedback and lookup on the same set: the lookup sees pre-update contents.
- Sweep length: exactly 2^SETS_LOG2 cycles from reset deassertion or flush. ready rises on the following cycle.
- Reset asserted mid-sweep or mid-update: state aborts immediately and the sweep restarts.

## Configuration
- BTB_COUNTER_EN defined:
  - 2-bit saturating counter per entry; branch = counter[1].
  - On hit, taken increments (saturating at 3) and not-taken decrements (saturating at 0).
  - Allocation only on taken misses, with initial counter 2'b10.
  - Not-taken misses are dropped.
- BTB_COUNTER_EN undefined:
  - 1-bit flag = last fb_taken; branch = flag.
  - Every feedback miss allocates, with flag = fb_taken.

## Structure
- Shared package btb_pkg: FSM state enum (BTB_INIT, BTB_READY), counter constants (CTR_WEAK_TAKEN=2'b10, CTR_MAX=2'b11).
- Entry struct is declared locally because its widths depend on parameters.
- Sub-module btb_victim_select: takes the set's valid vector and rr pointer, and returns the victim way plus an evict flag (priority to first invalid way).

## Test plan
PC_W=8, SETS_LOG2=2, WAYS=2.
1. Release reset → ready=0 for 4 cycles, ready=1 on 5th; lookup pc=0x05 during and after → hit=0, branch=0, target=0.
2. fb 0x05 taken target 0x20 → next cycle lookup 0x05: hit=1, branch=1, target=0x20; lookup 0x09: hit=0.
3. fb taken 0x05→way0, 0x09→way1, 0x0D→evicts way0 (rr 0→1) → lookups: 0x05 miss, 0x09 hit, 0x0D hit; fb 0x11 evicts 0x09.
4. BTB_COUNTER_EN: 0x05 allocated (10). Feedback not-taken → branch=0 (01). Not-taken again → branch=0 (00). Taken → branch=0 (01). Taken → branch=1 (10). A not-taken fb to 0x15 (miss) must not allocate.
5. BTB populated, pulse flush → ready=0 for 4 cycles, every lookup misses; fb 0x05 taken during sweep is ignored (still miss after ready).
6. fb 0x05 taken with lookup 0x05 in same cycle → hit=0 that cycle, hit=1 next cycle.

Source files
------------

// File: rtl/btb_pkg.sv
// Shared types and constants for the set-associative branch target buffer.
package btb_pkg;

  typedef enum logic {
    BTB_INIT,
    BTB_READY
  } btb_state_e;

  localparam logic [1:0] CTR_WEAK_TAKEN = 2'b10;
  localparam logic [1:0] CTR_MAX        = 2'b11;

endpackage

// File: rtl/btb_victim_select.sv
// Victim way choice for one set: lowest-index invalid way, otherwise the
// round-robin way, in which case a valid entry is evicted.
module btb_victim_select #(
  parameter int unsigned WAYS = 2,
  parameter int unsigned RR_W = $clog2(WAYS)
) (
  input  logic [WAYS-1:0] valid_i,
  input  logic [RR_W-1:0] rr_i,
  output logic [RR_W-1:0] victim_o,
  output logic            evict_o
);

  always_comb begin
    victim_o = rr_i;
    evict_o  = &valid_i;
    // Scan downward so the lowest invalid way wins.
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_i[w]) victim_o = RR_W'(w);
    end
  end

endmodule

// File: rtl/assoc_branch_target_buffer.sv
// Set-associative BTB with round-robin replacement and a sweep-based invalidation.
// Define BTB_COUNTER_EN for 2-bit direction counters instead of a last-outcome flag.
module assoc_branch_target_buffer
  import btb_pkg::*;
#(
  parameter int unsigned PC_W      = 16,
  parameter int unsigned SETS_LOG2 = 4,
  parameter int unsigned WAYS      = 2
) (
  input  logic            clk,
  input  logic            n_rst,
  input  logic            flush,
  input  logic [PC_W-1:0] pc,
  output logic            hit,
  output logic            branch,
  output logic [PC_W-1:0] target,
  output logic            ready,
  input  logic            fb_valid,
  input  logic [PC_W-1:0] fb_pc,
  input  logic            fb_taken,
  input  logic [PC_W-1:0] fb_target
);

  localparam int unsigned SETS  = 1 << SETS_LOG2;
  localparam int unsigned TAG_W = PC_W - SETS_LOG2;
  localparam int unsigned RR_W  = $clog2(WAYS);
`ifdef BTB_COUNTER_EN
  localparam int unsigned DIR_W = 2;
`else
  localparam int unsigned DIR_W = 1;
`endif

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [PC_W-1:0]  target;
    logic [DIR_W-1:0] dir;
  } entry_t;

  entry_t           mem_q  [SETS][WAYS];
  entry_t           mem_d  [SETS][WAYS];
  logic [RR_W-1:0]  rr_q   [SETS];
  logic [RR_W-1:0]  rr_d   [SETS];
  btb_state_e       state_q, state_d;
  logic [SETS_LOG2-1:0] init_idx_q, init_idx_d;

  logic [SETS_LOG2-1:0] lk_idx, fb_idx;
  logic [TAG_W-1:0]     lk_tag, fb_tag;
  logic                 fb_hit, fb_alloc, fb_evict;
  logic [RR_W-1:0]      fb_way, fb_victim;
  logic [WAYS-1:0]      fb_set_valid;
  logic [DIR_W-1:0]     dir_init;

  assign lk_idx = pc[SETS_LOG2-1:0];
  assign lk_tag = pc[PC_W-1:SETS_LOG2];
  assign fb_idx = fb_pc[SETS_LOG2-1:0];
  assign fb_tag = fb_pc[PC_W-1:SETS_LOG2];
  assign ready  = n_rst && (state_q == BTB_READY);

`ifdef BTB_COUNTER_EN
  assign fb_alloc = fb_taken;
  assign dir_init = CTR_WEAK_TAKEN;
`else
  assign fb_alloc = 1'b1;
  assign dir_init = fb_taken;
`endif

  // Lookup; tags are unique per set so the OR-style select is safe.
  always_comb begin
    hit    = 1'b0;
    branch = 1'b0;
    target = '0;
    if (ready) begin
      for (int w = 0; w < WAYS; w++) begin
        if (mem_q[lk_idx][w].valid && mem_q[lk_idx][w].tag == lk_tag) begin
          hit    = 1'b1;
          branch = mem_q[lk_idx][w].dir[DIR_W-1];
          target = mem_q[lk_idx][w].target;
        end
      end
    end
  end

  always_comb begin
    fb_hit = 1'b0;
    fb_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      fb_set_valid[w] = mem_q[fb_idx][w].valid;
      if (mem_q[fb_idx][w].valid && mem_q[fb_idx][w].tag == fb_tag) begin
        fb_hit = 1'b1;
        fb_way = RR_W'(w);
      end
    end
  end

  btb_victim_select #(
    .WAYS (WAYS),
    .RR_W (RR_W)
  ) u_victim (
    .valid_i  (fb_set_valid),
    .rr_i     (rr_q[fb_idx]),
    .victim_o (fb_victim),
    .evict_o  (fb_evict)
  );

  always_comb begin
    state_d    = state_q;
    init_idx_d = init_idx_q;
    mem_d      = mem_q;
    rr_d       = rr_q;
    unique case (state_q)
      BTB_INIT: begin
        for (int w = 0; w < WAYS; w++) mem_d[init_idx_q][w].valid = 1'b0;
        rr_d[init_idx_q] = '0;
        if (flush) begin
          init_idx_d = '0;
        end else begin
          init_idx_d = init_idx_q + 1'b1;
          if (init_idx_q == '1) state_d = BTB_READY;
        end
      end
      BTB_READY: begin
        if (fb_valid) begin
          if (fb_hit) begin
            if (fb_taken) mem_d[fb_idx][fb_way].target = fb_target;
`ifdef BTB_COUNTER_EN
            if (fb_taken && mem_q[fb_idx][fb_way].dir != CTR_MAX) begin
              mem_d[fb_idx][fb_way].dir = mem_q[fb_idx][fb_way].dir + 1'b1;
            end else if (!fb_taken && mem_q[fb_idx][fb_way].dir != '0) begin
              mem_d[fb_idx][fb_way].dir = mem_q[fb_idx][fb_way].dir - 1'b1;
            end
`else
            mem_d[fb_idx][fb_way].dir = fb_taken;
`endif
          end else if (fb_alloc) begin
            mem_d[fb_idx][fb_victim] = '{valid: 1'b1, tag: fb_tag, target: fb_target,
                                         dir: dir_init};
            if (fb_evict) rr_d[fb_idx] = rr_q[fb_idx] + 1'b1;
          end
        end
        if (flush) begin
          state_d    = BTB_INIT;
          init_idx_d = '0;
        end
      end
      default: state_d = BTB_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q    <= BTB_INIT;
      init_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      init_idx_q <= init_idx_d;
    end
  end

  // Entry storage is not reset; the sweep invalidates it. Writes are dropped under reset.
  always_ff @(posedge clk) begin
    if (n_rst) begin
      mem_q <= mem_d;
      rr_q  <= rr_d;
    end
  end

endmodule

// File: tb/tb_assoc_branch_target_buffer.sv
// Directed, table-driven bench for assoc_branch_target_buffer (PC_W=8, 4 sets, 2 ways).
module tb_assoc_branch_target_buffer;

  logic       clk = 1'b0;
  logic       n_rst, flush, fb_valid, fb_taken;
  logic [7:0] pc, fb_pc, fb_target;
  logic       hit, branch, ready;
  logic [7:0] target;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       fb_v;
    logic [7:0] fb_pc;
    logic       fb_t;
    logic [7:0] fb_tgt;
    logic [7:0] pc;
    logic       e_hit;
    logic       e_br;
    logic [7:0] e_tgt;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  assoc_branch_target_buffer #(
    .PC_W      (8),
    .SETS_LOG2 (2),
    .WAYS      (2)
  ) dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .flush     (flush),
    .pc        (pc),
    .hit       (hit),
    .branch    (branch),
    .target    (target),
    .ready     (ready),
    .fb_valid  (fb_valid),
    .fb_pc     (fb_pc),
    .fb_taken  (fb_taken),
    .fb_target (fb_target)
  );

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic add(input logic fv, input logic [7:0] fp, input logic ft, input logic [7:0] fg,
                     input logic [7:0] p, input logic eh, input logic eb, input logic [7:0] et);
    vec_t v;
    v.fb_v = fv; v.fb_pc = fp; v.fb_t = ft; v.fb_tgt = fg;
    v.pc = p; v.e_hit = eh; v.e_br = eb; v.e_tgt = et;
    vecs.push_back(v);
  endtask

  // Drive one cycle of inputs at the falling edge and check the combinational lookup.
  task automatic step(input string nm, input logic fv, input logic [7:0] fp, input logic ft,
                      input logic [7:0] fg, input logic fl, input logic [7:0] p,
                      input logic e_rdy, input logic eh, input logic eb, input logic [7:0] et);
    @(negedge clk);
    fb_valid = fv; fb_pc = fp; fb_taken = ft; fb_target = fg; flush = fl; pc = p;
    #1;
    chk({nm, ".ready"}, 32'(ready), 32'(e_rdy));
    chk({nm, ".hit"}, 32'(hit), 32'(eh));
    chk({nm, ".branch"}, 32'(branch), 32'(eb));
    chk({nm, ".target"}, 32'(target), 32'(et));
  endtask

  initial begin
    // Same-set (index 1) eviction sequence, valid for both direction modes.
    add(1, 8'h05, 1, 8'h20, 8'h05, 0, 0, 8'h00); // same-cycle lookup sees old contents
    add(0, 8'h00, 0, 8'h00, 8'h05, 1, 1, 8'h20);
    add(0, 8'h00, 0, 8'h00, 8'h09, 0, 0, 8'h00);
    add(1, 8'h09, 1, 8'h30, 8'h05, 1, 1, 8'h20); // fills way1
    add(1, 8'h0D, 1, 8'h40, 8'h09, 1, 1, 8'h30); // evicts way0 (05)
    add(0, 8'h00, 0, 8'h00, 8'h05, 0, 0, 8'h00);
    add(0, 8'h00, 0, 8'h00, 8'h0D, 1, 1, 8'h40);
    add(1, 8'h11, 1, 8'h50, 8'h09, 1, 1, 8'h30); // evicts way1 (09)
    add(0, 8'h00, 0, 8'h00, 8'h09, 0, 0, 8'h00);
    add(0, 8'h00, 0, 8'h00, 8'h11, 1, 1, 8'h50);
`ifdef BTB_COUNTER_EN
    add(1, 8'h0D, 0, 8'h77, 8'h0D, 1, 1, 8'h40); // 10 -> 01
    add(1, 8'h0D, 0, 8'h77, 8'h0D, 1, 0, 8'h40); // 01 -> 00
    add(1, 8'h0D, 1, 8'h41, 8'h0D, 1, 0, 8'h40); // 00 -> 01
    add(1, 8'h0D, 1, 8'h42, 8'h0D, 1, 0, 8'h41); // 01 -> 10
    add(1, 8'h15, 0, 8'h66, 8'h0D, 1, 1, 8'h42); // not-taken miss dropped
    add(0, 8'h00, 0, 8'h00, 8'h15, 0, 0, 8'h00);
    add(1, 8'h0D, 1, 8'h43, 8'h0D, 1, 1, 8'h42); // 10 -> 11
    add(1, 8'h0D, 1, 8'h43, 8'h0D, 1, 1, 8'h43); // saturates at 11
    add(1, 8'h0D, 0, 8'h99, 8'h0D, 1, 1, 8'h43); // 11 -> 10
    add(0, 8'h00, 0, 8'h00, 8'h0D, 1, 1, 8'h43);
    add(0, 8'h00, 0, 8'h00, 8'h11, 1, 1, 8'h50);
`else
    add(1, 8'h0D, 0, 8'h77, 8'h0D, 1, 1, 8'h40);
    add(0, 8'h00, 0, 8'h00, 8'h0D, 1, 0, 8'h40); // flag cleared, target kept
    add(1, 8'h0D, 1, 8'h44, 8'h11, 1, 1, 8'h50);
    add(0, 8'h00, 0, 8'h00, 8'h0D, 1, 1, 8'h44);
    add(1, 8'h15, 0, 8'h66, 8'h0D, 1, 1, 8'h44); // not-taken miss allocates over way0
    add(0, 8'h00, 0, 8'h00, 8'h15, 1, 0, 8'h66);
    add(0, 8'h00, 0, 8'h00, 8'h0D, 0, 0, 8'h00);
    add(0, 8'h00, 0, 8'h00, 8'h11, 1, 1, 8'h50);
`endif
    // Other sets stay independent.
    add(1, 8'h02, 1, 8'h80, 8'h02, 0, 0, 8'h00);
    add(0, 8'h00, 0, 8'h00, 8'h02, 1, 1, 8'h80);
    add(1, 8'hFE, 1, 8'hAB, 8'h06, 0, 0, 8'h00);
    add(0, 8'h00, 0, 8'h00, 8'hFE, 1, 1, 8'hAB);
    add(0, 8'h00, 0, 8'h00, 8'h02, 1, 1, 8'h80);

    n_rst = 1'b0; flush = 0; fb_valid = 0; fb_pc = 0; fb_taken = 0; fb_target = 0; pc = 8'h05;
    repeat (2) @(negedge clk);
    #1;
    chk("rst.ready", 32'(ready), 0);
    chk("rst.hit", 32'(hit), 0);

    // Release reset: four sweep cycles, ready on the fifth; feedback during sweep ignored.
    n_rst = 1'b1;
    #1;
    chk("sweep0.ready", 32'(ready), 0);
    chk("sweep0.hit", 32'(hit), 0);
    for (int i = 1; i < 4; i++) step($sformatf("sweep%0d", i), 1, 8'h05, 1, 8'h20, 0, 8'h05,
                                     0, 0, 0, 8'h00);
    step("sweep_done", 0, 8'h00, 0, 8'h00, 0, 8'h05, 1, 0, 0, 8'h00);

    foreach (vecs[i]) begin
      step($sformatf("vec%0d", i), vecs[i].fb_v, vecs[i].fb_pc, vecs[i].fb_t, vecs[i].fb_tgt,
           0, vecs[i].pc, 1, vecs[i].e_hit, vecs[i].e_br, vecs[i].e_tgt);
    end

    // Flush from READY: entries still visible in the flush cycle, then four blank cycles.
    step("flush", 0, 8'h00, 0, 8'h00, 1, 8'h02, 1, 1, 1, 8'h80);
    step("fl_sw0", 1, 8'h05, 1, 8'h20, 0, 8'h02, 0, 0, 0, 8'h00);
    step("fl_sw1", 0, 8'h00, 0, 8'h00, 0, 8'h02, 0, 0, 0, 8'h00);
    // Second flush mid-sweep restarts it: four more INIT cycles follow.
    step("fl_re", 0, 8'h00, 0, 8'h00, 1, 8'h02, 0, 0, 0, 8'h00);
    for (int i = 0; i < 4; i++) step($sformatf("fl_re%0d", i), 0, 8'h00, 0, 8'h00, 0, 8'hFE,
                                     0, 0, 0, 8'h00);
    step("fl_done02", 0, 8'h00, 0, 8'h00, 0, 8'h02, 1, 0, 0, 8'h00);
    step("fl_done05", 0, 8'h00, 0, 8'h00, 0, 8'h05, 1, 0, 0, 8'h00);
    step("fl_doneFE", 1, 8'h06, 1, 8'h60, 0, 8'hFE, 1, 0, 0, 8'h00);
    step("post_fl", 0, 8'h00, 0, 8'h00, 0, 8'h06, 1, 1, 1, 8'h60);

    // Reset in the middle of a sweep restarts it from set 0.
    step("rst2_fl", 0, 8'h00, 0, 8'h00, 1, 8'h06, 1, 1, 1, 8'h60);
    step("rst2_a", 0, 8'h00, 0, 8'h00, 0, 8'h06, 0, 0, 0, 8'h00);
    step("rst2_b", 0, 8'h00, 0, 8'h00, 0, 8'h06, 0, 0, 0, 8'h00);
    @(negedge clk);
    n_rst = 1'b0;
    @(negedge clk);
    n_rst = 1'b1;
    for (int i = 0; i < 3; i++) step($sformatf("rst2_sw%0d", i), 0, 8'h00, 0, 8'h00, 0, 8'h06,
                                     0, 0, 0, 8'h00);
    step("rst2_done", 0, 8'h00, 0, 8'h00, 0, 8'h06, 1, 0, 0, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
